// File: rtl/id_issue_stage_pkg.sv
// Shared constants for the decode/issue stage: default datapath widths and boolean literals.
package id_issue_stage_pkg;

    localparam int XLEN_DEF          = 32;
    localparam int RF_ADDR_WIDTH_DEF = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/id_issue_stage_operand_sel.sv
// Priority forwarding mux for one source operand: x0, then youngest matching
// forwarding source, then register file.
module id_operand_sel
    import id_issue_stage_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int NUM_FW        = 2
) (
    input  logic [RF_ADDR_WIDTH-1:0]        addr,
    input  logic [XLEN-1:0]                 rf_rdata,
    input  logic [NUM_FW-1:0]               fw_valid,
    input  logic [NUM_FW-1:0]               fw_data_rdy,
    input  logic [NUM_FW*RF_ADDR_WIDTH-1:0] fw_addr,
    input  logic [NUM_FW*XLEN-1:0]          fw_data,
    output logic [XLEN-1:0]                 data,
    output logic                            not_ready
);

    logic hit;

    always_comb begin
        data      = rf_rdata;
        not_ready = FALSE;
        hit       = FALSE;
        if (addr == '0) begin
            data = '0;
        end else begin
            // Index 0 is the youngest source, so the first hit wins.
            for (int i = 0; i < NUM_FW; i++) begin
                if (!hit && fw_valid[i] &&
                    fw_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == addr) begin
                    hit       = TRUE;
                    data      = fw_data[i*XLEN +: XLEN];
                    not_ready = ~fw_data_rdy[i];
                end
            end
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: operand forwarding, load-use and long-latency hazard checks, ID/EX slot.
// ID_LL_SCOREBOARD_EN selects a per-register LL scoreboard; otherwise a single busy flag.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int NUM_FW        = 2,
    parameter int DEC_W         = 64,
    parameter int CNT_W         = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [XLEN-1:0]                 in_pc,
    input  logic [XLEN-1:0]                 in_inst,
    input  logic [DEC_W-1:0]                in_dec,
    input  logic [RF_ADDR_WIDTH-1:0]        in_rs1_addr,
    input  logic [RF_ADDR_WIDTH-1:0]        in_rs2_addr,
    input  logic                            in_rs1_used,
    input  logic                            in_rs2_used,
    input  logic [RF_ADDR_WIDTH-1:0]        in_rd_addr,
    input  logic                            in_req_rf,
    input  logic                            in_is_ll,
    output logic [RF_ADDR_WIDTH-1:0]        rf_raddr1,
    output logic [RF_ADDR_WIDTH-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]                 rf_rdata1,
    input  logic [XLEN-1:0]                 rf_rdata2,
    input  logic [NUM_FW-1:0]               fw_valid,
    input  logic [NUM_FW-1:0]               fw_data_rdy,
    input  logic [NUM_FW*RF_ADDR_WIDTH-1:0] fw_addr,
    input  logic [NUM_FW*XLEN-1:0]          fw_data,
    input  logic                            ll_wb_valid,
    input  logic [RF_ADDR_WIDTH-1:0]        ll_wb_addr,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [XLEN-1:0]                 out_pc,
    output logic [XLEN-1:0]                 out_inst,
    output logic [XLEN-1:0]                 out_rs1,
    output logic [XLEN-1:0]                 out_rs2,
    output logic [DEC_W-1:0]                out_dec,
    output logic [RF_ADDR_WIDTH-1:0]        out_rd_addr,
    output logic                            out_req_rf,
    output logic                            out_is_ll,
    output logic [CNT_W-1:0]                stall_cycles
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_nrdy, rs2_nrdy;
    logic            load_use, ll_hazard, hazard, transfer, issue_ll;

    assign rf_raddr1 = in_rs1_addr;
    assign rf_raddr2 = in_rs2_addr;

    id_operand_sel #(.XLEN(XLEN), .RF_ADDR_WIDTH(RF_ADDR_WIDTH), .NUM_FW(NUM_FW)) u_sel_rs1 (
        .addr(in_rs1_addr), .rf_rdata(rf_rdata1), .fw_valid(fw_valid), .fw_data_rdy(fw_data_rdy),
        .fw_addr(fw_addr), .fw_data(fw_data), .data(rs1_data), .not_ready(rs1_nrdy)
    );

    id_operand_sel #(.XLEN(XLEN), .RF_ADDR_WIDTH(RF_ADDR_WIDTH), .NUM_FW(NUM_FW)) u_sel_rs2 (
        .addr(in_rs2_addr), .rf_rdata(rf_rdata2), .fw_valid(fw_valid), .fw_data_rdy(fw_data_rdy),
        .fw_addr(fw_addr), .fw_data(fw_data), .data(rs2_data), .not_ready(rs2_nrdy)
    );

    assign load_use = (in_rs1_used & rs1_nrdy) | (in_rs2_used & rs2_nrdy);
    assign issue_ll = out_valid & out_ready & out_is_ll & out_req_rf &
                      (out_rd_addr != '0) & ~flush;

`ifdef ID_LL_SCOREBOARD_EN
    localparam int NREG = 1 << RF_ADDR_WIDTH;

    logic [NREG-1:0] pending;
    logic            dep1, dep2;

    // An LL op still sitting in the slot is not yet in the scoreboard, so match it directly.
    assign dep1 = in_rs1_used & (in_rs1_addr != '0) &
                  (pending[in_rs1_addr] | (out_valid & out_is_ll & (out_rd_addr == in_rs1_addr)));
    assign dep2 = in_rs2_used & (in_rs2_addr != '0) &
                  (pending[in_rs2_addr] | (out_valid & out_is_ll & (out_rd_addr == in_rs2_addr)));
    assign ll_hazard = dep1 | dep2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue_ll && out_rd_addr == RF_ADDR_WIDTH'(r))
                    pending[r] <= 1'b1;
                else if (ll_wb_valid && ll_wb_addr == RF_ADDR_WIDTH'(r))
                    pending[r] <= 1'b0;
            end
        end
    end
`else
    logic busy;
    logic ll_wb_addr_unused;

    assign ll_wb_addr_unused = ^ll_wb_addr;
    assign ll_hazard = busy | (out_valid & out_is_ll);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= 1'b0;
        else if (issue_ll)
            busy <= 1'b1;
        else if (ll_wb_valid)
            busy <= 1'b0;
    end
`endif

    assign hazard   = load_use | ll_hazard;
    assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
    assign transfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (in_valid && !in_ready && !flush)
            stall_cycles <= sat_inc(stall_cycles);
    end

    // ID/EX slot boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_dec     <= '0;
            out_rd_addr <= '0;
            out_req_rf  <= 1'b0;
            out_is_ll   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_inst    <= in_inst;
            out_rs1     <= rs1_data;
            out_rs2     <= rs2_data;
            out_dec     <= in_dec;
            out_rd_addr <= in_rd_addr;
            out_req_rf  <= in_req_rf;
            out_is_ll   <= in_is_ll;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
